// File: rtl/mux_n_pipe_pkg.sv
// rtl/mux_n_pipe_pkg.sv - shared constants and helpers for the pipelined N:1 selector
// Out-of-range policy encoding, select-width helper and reset data value.
package mux_pkg;

  typedef enum logic {
    OOR_CH0       = 1'b0,
    OOR_ZERO_DATA = 1'b1
  } oor_policy_e;

  localparam logic RST_DATA_BIT = 1'b0;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_pipe_if.sv
// rtl/mux_n_pipe_if.sv - valid/ready bundle for the pipelined N:1 selector
// master drives the input side and consumes the output side; slave is the block.
interface mux_n_pipe_if
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  localparam int SEL_W = sel_width(N);

  logic                 in_valid;
  logic                 in_ready;
  logic [SEL_W-1:0]     sel_i;
  logic [N*WIDTH-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 sel_err;

  modport master (
    output in_valid, sel_i, in_data, out_ready,
    input  in_ready, out_valid, out_data, sel_err
  );

  modport slave (
    input  in_valid, sel_i, in_data, out_ready,
    output in_ready, out_valid, out_data, sel_err
  );
endinterface

// File: rtl/mux_n_pipe_comb.sv
// rtl/mux_n_pipe_comb.sv - combinational N:1 WIDTH-bit selector
// Out-of-range selects give zero or channel 0 depending on OOR_ZERO.
module mux_n_comb
  import mux_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int N        = 4,
  parameter int OOR_ZERO = 1,
  parameter int SEL_W    = sel_width(N)
) (
  input  logic [SEL_W-1:0]   sel,
  input  logic [N*WIDTH-1:0] data,
  output logic [WIDTH-1:0]   word
);

  always_comb begin
    if (OOR_ZERO == int'(OOR_ZERO_DATA)) begin
      word = {WIDTH{RST_DATA_BIT}};
    end else begin
      word = data[0 +: WIDTH];
    end
    for (int k = 0; k < N; k++) begin
      if ({1'b0, sel} == (SEL_W + 1)'(k)) begin
        word = data[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// rtl/mux_n_pipe.sv - registered N:1 selector with skid buffer, valid/ready both sides
// Optional sticky out-of-range flag built only when MUX_SEL_CHECK_EN is defined.
module mux_n_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int N        = 4,
  parameter int OOR_ZERO = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_n_pipe_if.slave    bus
);

  localparam int SEL_W = sel_width(N);

  logic [WIDTH-1:0] sel_word;
  logic             m_valid, m_valid_n;
  logic             s_valid, s_valid_n;
  logic [WIDTH-1:0] m_data, m_data_n;
  logic [WIDTH-1:0] s_data, s_data_n;
  logic             in_ready_q;
  logic             push;
  logic             pop;

  mux_n_comb #(
    .WIDTH    (WIDTH),
    .N        (N),
    .OOR_ZERO (OOR_ZERO),
    .SEL_W    (SEL_W)
  ) u_sel (
    .sel  (bus.sel_i),
    .data (bus.in_data),
    .word (sel_word)
  );

  assign push = bus.in_valid & in_ready_q;
  assign pop  = m_valid & bus.out_ready;

  // S is only ever filled while M is full and stalled, so M can never be empty with S valid.
  always_comb begin
    m_valid_n = m_valid;
    m_data_n  = m_data;
    s_valid_n = s_valid;
    s_data_n  = s_data;
    if (!m_valid) begin
      if (push) begin
        m_valid_n = 1'b1;
        m_data_n  = sel_word;
      end
    end else if (pop) begin
      if (s_valid) begin
        m_data_n  = s_data;
        s_valid_n = 1'b0;
      end else if (push) begin
        m_data_n  = sel_word;
      end else begin
        m_valid_n = 1'b0;
      end
    end else if (push) begin
      s_valid_n = 1'b1;
      s_data_n  = sel_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      s_valid    <= 1'b0;
      m_data     <= {WIDTH{RST_DATA_BIT}};
      s_data     <= {WIDTH{RST_DATA_BIT}};
      in_ready_q <= 1'b1;
    end else begin
      m_valid    <= m_valid_n;
      s_valid    <= s_valid_n;
      m_data     <= m_data_n;
      s_data     <= s_data_n;
      in_ready_q <= !s_valid_n;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = m_valid;
  assign bus.out_data  = m_data;

`ifdef MUX_SEL_CHECK_EN
  localparam logic [SEL_W:0] N_L = (SEL_W + 1)'(N);

  logic sel_oor;
  logic sel_err_q;

  assign sel_oor = push && ({1'b0, bus.sel_i} >= N_L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else if (sel_oor) begin
      sel_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && sel_oor) begin
      $error("mux_n_pipe: select %0d out of range for N=%0d", bus.sel_i, N);
    end
  end

  assign bus.sel_err = sel_err_q;
`else
  assign bus.sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// tb/tb_mux_n_pipe.sv - bench for mux_n_pipe: N=4 plus two N=3 variants against a queue model
module tb_mux_n_pipe;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [1:0]   sel = 2'd0;
  logic [127:0] data = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic        err1 = 1'b0;

  always #5 clk = ~clk;

  mux_n_pipe_if #(.WIDTH(32), .N(4)) if0 ();
  mux_n_pipe_if #(.WIDTH(32), .N(3)) if1 ();
  mux_n_pipe_if #(.WIDTH(32), .N(3)) if2 ();

  assign if0.in_valid = in_valid;
  assign if0.out_ready = out_ready;
  assign if0.sel_i = sel;
  assign if0.in_data = data;
  assign if1.in_valid = in_valid;
  assign if1.out_ready = out_ready;
  assign if1.sel_i = sel;
  assign if1.in_data = data[95:0];
  assign if2.in_valid = in_valid;
  assign if2.out_ready = out_ready;
  assign if2.sel_i = sel;
  assign if2.in_data = data[95:0];

  mux_n_pipe #(.WIDTH(32), .N(4), .OOR_ZERO(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  mux_n_pipe #(.WIDTH(32), .N(3), .OOR_ZERO(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  mux_n_pipe #(.WIDTH(32), .N(3), .OOR_ZERO(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  function automatic logic [31:0] exp_word(input int n, input int oor, input logic [1:0] s,
                                           input logic [127:0] d);
    if (int'(s) < n) return d[int'(s)*32 +: 32];
    return (oor != 0) ? 32'h0 : d[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: the block is a 2-deep FIFO; acceptance while fewer than two words are held.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      q2.delete();
      err1 = 1'b0;
    end else begin
      automatic bit do_push = in_valid && (q0.size() < 2);
      automatic bit do_pop  = out_ready && (q0.size() > 0);
      if (do_pop) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
        void'(q2.pop_front());
      end
      if (do_push) begin
        q0.push_back(exp_word(4, 1, sel, data));
        q1.push_back(exp_word(3, 1, sel, data));
        q2.push_back(exp_word(3, 0, sel, data));
        if (sel == 2'd3) err1 = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    automatic logic exp_err = 1'b0;
`ifdef MUX_SEL_CHECK_EN
    exp_err = err1;
`endif
    chk("d0.in_ready", 32'(if0.in_ready), 32'(q0.size() < 2));
    chk("d0.out_valid", 32'(if0.out_valid), 32'(q0.size() > 0));
    if (q0.size() > 0) chk("d0.out_data", if0.out_data, q0[0]);
    chk("d0.sel_err", 32'(if0.sel_err), 32'd0);
    chk("d1.out_valid", 32'(if1.out_valid), 32'(q1.size() > 0));
    if (q1.size() > 0) chk("d1.out_data", if1.out_data, q1[0]);
    chk("d1.sel_err", 32'(if1.sel_err), 32'(exp_err));
    chk("d2.in_ready", 32'(if2.in_ready), 32'(q2.size() < 2));
    if (q2.size() > 0) chk("d2.out_data", if2.out_data, q2[0]);
    chk("d2.sel_err", 32'(if2.sel_err), 32'(exp_err));
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step(input logic v, input logic [1:0] s, input logic [127:0] d, input logic r);
    in_valid = v;
    sel = s;
    data = d;
    out_ready = r;
    @(negedge clk);
  endtask

  initial begin
    logic [127:0] d;
    logic [127:0] da;
    logic [127:0] db;
    logic exp_sticky;

    exp_sticky = 1'b0;
`ifdef MUX_SEL_CHECK_EN
    exp_sticky = 1'b1;
`endif

    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b1, 2'(i), rnd128(), 1'b1);
    chk("rst.out_valid", 32'(if0.out_valid), 32'd0);
    chk("rst.out_data", if0.out_data, 32'h0);
    chk("rst.in_ready", 32'(if0.in_ready), 32'd1);

    rst_n = 1'b1;
    d = rnd128();
    d[95:64] = 32'hDEAD_BEEF;
    step(1'b1, 2'd2, d, 1'b1);
    chk("first.out_data", if0.out_data, 32'hDEAD_BEEF);
    chk("first.out_valid", 32'(if0.out_valid), 32'd1);
    step(1'b0, 2'd0, '0, 1'b1);

    for (int i = 0; i < 16; i++) begin
      step(1'b1, 2'(i % 4), rnd128(), 1'b1);
      chk("stream.in_ready", 32'(if0.in_ready), 32'd1);
      chk("stream.out_valid", 32'(if0.out_valid), 32'd1);
    end
    step(1'b0, 2'd0, '0, 1'b1);

    da = rnd128();
    db = rnd128();
    step(1'b1, 2'd0, da, 1'b0);
    step(1'b1, 2'd1, db, 1'b0);
    chk("bp.hold_a", if0.out_data, da[31:0]);
    chk("bp.in_ready_low", 32'(if0.in_ready), 32'd0);
    step(1'b0, 2'd0, '0, 1'b0);
    chk("bp.still_a", if0.out_data, da[31:0]);
    step(1'b0, 2'd0, '0, 1'b1);
    chk("bp.pop_b", if0.out_data, db[63:32]);
    chk("bp.in_ready_back", 32'(if0.in_ready), 32'd1);
    step(1'b0, 2'd0, '0, 1'b1);
    chk("bp.empty", 32'(if0.out_valid), 32'd0);

    da = rnd128();
    db = rnd128();
    step(1'b1, 2'd3, da, 1'b0);
    chk("pp.first", if0.out_data, da[127:96]);
    step(1'b1, 2'd2, db, 1'b1);
    chk("pp.replaced", if0.out_data, db[95:64]);
    chk("pp.out_valid", 32'(if0.out_valid), 32'd1);
    chk("pp.in_ready", 32'(if0.in_ready), 32'd1);
    step(1'b0, 2'd0, '0, 1'b1);

    d = rnd128();
    step(1'b1, 2'd3, d, 1'b1);
    chk("oor.zero", if1.out_data, 32'h0);
    chk("oor.ch0", if2.out_data, d[31:0]);
    chk("oor.err_next", 32'(if1.sel_err), 32'(exp_sticky));
    for (int i = 0; i < 3; i++) step(1'b1, 2'(i), rnd128(), 1'b1);
    chk("oor.err_sticky", 32'(if2.sel_err), 32'(exp_sticky));
    step(1'b0, 2'd0, '0, 1'b1);

    step(1'b1, 2'd0, rnd128(), 1'b0);
    step(1'b1, 2'd1, rnd128(), 1'b0);
    chk("ar.s_full", 32'(if0.in_ready), 32'd0);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar.out_valid", 32'(if0.out_valid), 32'd0);
    chk("ar.in_ready", 32'(if0.in_ready), 32'd1);
    chk("ar.sel_err", 32'(if1.sel_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 2'd0, '0, 1'b1);
    step(1'b0, 2'd0, '0, 1'b1);
    chk("ar.no_stale", 32'(if0.out_valid), 32'd0);

    for (int i = 0; i < 800; i++) begin
      step(($urandom % 4) != 0, 2'($urandom % 4), rnd128(), ($urandom % 3) != 0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, '0, 1'b1);
    chk("end.drained", 32'(if0.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1);
  end

endmodule
